// File: rtl/cordic_job_sequencer.sv
// Job sequencer around the CORDIC control FSM: a request FIFO feeds one job at a time
// to the CORDIC, and a single-entry output register holds each result for the consumer.
module cordic_job_sequencer #(
    parameter int W     = 32,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_angle,
    input  logic          in_op,
    output logic [W-1:0]  angle_cordic,
    output logic          operation,
    output logic          beg_FSM_CORDIC,
    input  logic          ready_CORDIC,
    input  logic [W-1:0]  data_cordic,
    output logic          ACK_FSM_CORDIC,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic          out_op,
    output logic [AW:0]   count,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, START, WAIT, ACK} state_t;

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    state_t         state_reg, state_next;
    logic [W:0]     mem [DEPTH];
    logic [AW-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]    count_reg, count_next;
    logic [W-1:0]   angle_reg;
    logic           op_reg;
    logic           out_valid_reg, out_valid_next;
    logic [W-1:0]   out_data_reg;
    logic           out_op_reg;
    logic           push, pop, out_free, capture;

    assign in_ready = (count_reg != FULL_COUNT);
    assign push     = in_valid && in_ready;
    assign pop      = (state_reg == IDLE) && (count_reg != '0);
    // The output slot counts as free when its current result drains at this same edge.
    assign out_free = !out_valid_reg || out_ready;
    assign capture  = (state_reg == WAIT) && ready_CORDIC && out_free;

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + (AW+1)'(1);
            2'b01:   count_next = count_reg - (AW+1)'(1);
            default: count_next = count_reg;
        endcase
    end

    always_comb begin
        out_valid_next = out_valid_reg;
        if (capture)
            out_valid_next = 1'b1;
        else if (out_valid_reg && out_ready)
            out_valid_next = 1'b0;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (count_reg != '0) state_next = START;
            START:   state_next = WAIT;
            WAIT:    if (capture) state_next = ACK;
            ACK:     if (!ready_CORDIC) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Storage array has no reset so it can map onto RAM; only pointers are cleared.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg] <= {in_op, in_angle};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            angle_reg     <= '0;
            op_reg        <= 1'b0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_op_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            out_valid_reg <= out_valid_next;
            if (push)
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
                {op_reg, angle_reg} <= mem[rd_ptr_reg];
            end
            if (capture) begin
                out_data_reg <= data_cordic;
                out_op_reg   <= op_reg;
            end
        end
    end

    assign beg_FSM_CORDIC = (state_reg == START);
    assign ACK_FSM_CORDIC = (state_reg == ACK);
    assign angle_cordic   = angle_reg;
    assign operation      = op_reg;
    assign out_valid      = out_valid_reg;
    assign out_data       = out_data_reg;
    assign out_op         = out_op_reg;
    assign count          = count_reg;
    assign busy           = (state_reg != IDLE) || (count_reg != '0) || out_valid_reg;

endmodule

// File: tb/tb_cordic_job_sequencer.sv
// Directed bench for cordic_job_sequencer with a small behavioural CORDIC handshake model.
`timescale 1ns/1ps
module tb_cordic_job_sequencer;

    localparam int W     = 32;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_angle = '0;
    logic          in_op = 1'b0;
    logic [W-1:0]  angle_cordic;
    logic          operation;
    logic          beg_FSM_CORDIC;
    logic          ready_CORDIC = 1'b0;
    logic [W-1:0]  data_cordic = '0;
    logic          ACK_FSM_CORDIC;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic          out_op;
    logic [AW:0]   count;
    logic          busy;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    logic [W-1:0] model_q[$];
    int           model_lat   = 20;
    bit           cordic_hold = 1'b0;
    int           m_phase     = 0;
    int           m_cnt       = 0;
    logic         beg_seen;

    // Job tables for the queue-fill test: angle, op, CORDIC result.
    logic [W-1:0] t2_ang [6] = '{32'h4000_0000, 32'h4000_0011, 32'h4000_0022,
                                 32'h4000_0033, 32'h4000_0044, 32'h4000_0055};
    logic         t2_op  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [W-1:0] t2_res [6] = '{32'hC000_0A00, 32'hC000_0A11, 32'hC000_0A22,
                                 32'hC000_0A33, 32'hC000_0A44, 32'hC000_0A55};

    cordic_job_sequencer #(.W(W), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_angle       (in_angle),
        .in_op          (in_op),
        .angle_cordic   (angle_cordic),
        .operation      (operation),
        .beg_FSM_CORDIC (beg_FSM_CORDIC),
        .ready_CORDIC   (ready_CORDIC),
        .data_cordic    (data_cordic),
        .ACK_FSM_CORDIC (ACK_FSM_CORDIC),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_op         (out_op),
        .count          (count),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // CORDIC model: takes a job on beg, raises ready after model_lat cycles, drops it on ACK.
    initial begin : cordic_model
        forever begin
            @(negedge clk);
            if (!reset) begin
                m_phase = 0;
                ready_CORDIC = 1'b0;
            end else begin
                case (m_phase)
                    0: if (beg_FSM_CORDIC) begin
                        m_phase = 1;
                        m_cnt = model_lat - 1;
                        if (model_q.size() > 0) data_cordic = model_q.pop_front();
                        else data_cordic = '0;
                    end
                    1: if (!cordic_hold) begin
                        if (m_cnt <= 0) begin
                            ready_CORDIC = 1'b1;
                            m_phase = 2;
                        end else begin
                            m_cnt--;
                        end
                    end
                    default: if (ACK_FSM_CORDIC) begin
                        ready_CORDIC = 1'b0;
                        m_phase = 0;
                    end
                endcase
            end
        end
    end

    // Called just after a falling edge; returns one falling edge after acceptance.
    task automatic push_req(input logic [W-1:0] a, input logic op, input logic [W-1:0] res);
        int guard = 0;
        in_valid = 1'b1;
        in_angle = a;
        in_op    = op;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) chk("push_timeout", in_ready, 1);
        model_q.push_back(res);
        @(negedge clk);
    endtask

    task automatic wait_out_valid(input string tag);
        int guard = 0;
        while (!out_valid && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!out_valid) chk({tag, "_timeout"}, out_valid, 1);
    endtask

    task automatic pop_result(input string tag, input logic [W-1:0] d, input logic op);
        wait_out_valid(tag);
        chk({tag, "_data"}, out_data, d);
        chk({tag, "_op"}, out_op, op);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin : watchdog
        #200us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        // ---- reset state
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_count", count, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_beg", beg_FSM_CORDIC, 0);
        chk("rst_ack", ACK_FSM_CORDIC, 0);
        chk("rst_angle", angle_cordic, 0);
        reset = 1'b1;
        @(negedge clk);

        // ---- test 1: single job, latency and handshake
        model_lat = 20;
        push_req(32'h3F80_0000, 1'b1, 32'h3F57_6AA4);
        in_valid = 1'b0;
        chk("t1_count_after_push", count, 1);
        chk("t1_beg_before_pop", beg_FSM_CORDIC, 0);
        @(negedge clk);
        chk("t1_beg_pulse", beg_FSM_CORDIC, 1);
        chk("t1_angle", angle_cordic, 32'h3F80_0000);
        chk("t1_operation", operation, 1);
        chk("t1_count_after_pop", count, 0);
        @(negedge clk);
        chk("t1_beg_one_cycle", beg_FSM_CORDIC, 0);
        wait_out_valid("t1");
        chk("t1_out_data", out_data, 32'h3F57_6AA4);
        chk("t1_out_op", out_op, 1);
        chk("t1_ack_high", ACK_FSM_CORDIC, 1);
        chk("t1_busy", busy, 1);
        @(negedge clk);
        chk("t1_ack_low", ACK_FSM_CORDIC, 0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("t1_out_valid_drained", out_valid, 0);
        chk("t1_busy_done", busy, 0);

        // ---- test 2: fill FIFO while CORDIC stalls, fifth request held
        model_lat = 3;
        cordic_hold = 1'b1;
        push_req(t2_ang[0], t2_op[0], t2_res[0]);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        fork
            begin
                for (int i = 1; i < 6; i++) push_req(t2_ang[i], t2_op[i], t2_res[i]);
                in_valid = 1'b0;
            end
            begin
                repeat (6) @(negedge clk);
                chk("t2_count_full", count, 4);
                chk("t2_in_ready_full", in_ready, 0);
                chk("t2_job0_in_flight", angle_cordic, t2_ang[0]);
                cordic_hold = 1'b0;
            end
        join
        for (int i = 0; i < 6; i++) pop_result($sformatf("t2_res%0d", i), t2_res[i], t2_op[i]);

        // ---- test 3: output backpressure stalls WAIT without ACK
        repeat (2) @(negedge clk);
        push_req(32'h3F00_0000, 1'b0, 32'h3F60_A000);
        push_req(32'h3E80_0000, 1'b1, 32'h3E7D_B000);
        in_valid = 1'b0;
        wait_out_valid("t3_a");
        repeat (20) @(negedge clk);
        chk("t3_pending_valid", out_valid, 1);
        chk("t3_pending_data", out_data, 32'h3F60_A000);
        chk("t3_no_ack", ACK_FSM_CORDIC, 0);
        chk("t3_busy", busy, 1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("t3_valid_stays", out_valid, 1);
        chk("t3_new_data", out_data, 32'h3E7D_B000);
        chk("t3_new_op", out_op, 1);
        chk("t3_ack_after_release", ACK_FSM_CORDIC, 1);
        pop_result("t3_b", 32'h3E7D_B000, 1'b1);

        // ---- test 4: push and pop on the same edge at count 1, pointers wrapped
        repeat (3) @(negedge clk);
        push_req(32'h4040_0000, 1'b0, 32'hBF7D_0000);
        chk("t4_count_one", count, 1);
        push_req(32'h4080_0000, 1'b1, 32'hBF41_0000);
        in_valid = 1'b0;
        chk("t4_count_push_pop", count, 1);
        chk("t4_angle_popped", angle_cordic, 32'h4040_0000);
        pop_result("t4_y", 32'hBF7D_0000, 1'b0);
        pop_result("t4_z", 32'hBF41_0000, 1'b1);

        // ---- test 5: asynchronous reset during WAIT with entries queued
        repeat (3) @(negedge clk);
        push_req(32'h3DCC_CCCD, 1'b1, 32'h3DCC_0000);
        in_valid = 1'b0;
        wait_out_valid("t5_p0");
        repeat (4) @(negedge clk);
        cordic_hold = 1'b1;
        push_req(32'h4100_0000, 1'b0, 32'h1111_1111);
        push_req(32'h4110_0000, 1'b0, 32'h2222_2222);
        push_req(32'h4120_0000, 1'b1, 32'h3333_3333);
        in_valid = 1'b0;
        chk("t5_count_two", count, 2);
        chk("t5_result_pending", out_valid, 1);
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("t5_async_count", count, 0);
        chk("t5_async_out_valid", out_valid, 0);
        chk("t5_async_beg", beg_FSM_CORDIC, 0);
        chk("t5_async_ack", ACK_FSM_CORDIC, 0);
        chk("t5_async_busy", busy, 0);
        chk("t5_async_in_ready", in_ready, 1);
        chk("t5_async_angle", angle_cordic, 0);
        repeat (2) @(negedge clk);
        model_q.delete();
        cordic_hold = 1'b0;
        reset = 1'b1;
        beg_seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            beg_seen = beg_seen | beg_FSM_CORDIC;
        end
        chk("t5_no_stale_issue", beg_seen, 0);
        chk("t5_count_after", count, 0);
        chk("t5_busy_after", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/cordic_job_sequencer.md
Name: cordic_job_sequencer

Overview:
Front/back-end wrapper around the CORDIC control FSM. It accepts angle requests (angle plus operation) from a host over a valid/ready interface and buffers them in a small FIFO. It issues each job to the CORDIC with a one-cycle beg_FSM_CORDIC pulse, captures the result when ready_CORDIC rises and acknowledges it with ACK_FSM_CORDIC. Results are presented to the consumer through a single-entry valid/ready output register.

Parameters:
W, 32, data width of angle and result (single-precision float).
DEPTH, 4, request FIFO depth; power of 2, at least 2.
AW, 2, log2(DEPTH).

Ports:
clk  in  1  system clock; all state changes on rising edge.
reset  in  1  asynchronous, active-low reset (asserted when 0); clears all state immediately.
in_valid  in  1  host request valid.
in_ready  out  1  FIFO can accept; equals (count < DEPTH).
in_angle  in  W  requested angle.
in_op  in  1  0 = cosine, 1 = sine.
angle_cordic  out  W  angle of the job currently issued.
operation  out  1  operation of the job currently issued.
beg_FSM_CORDIC  out  1  one-cycle start pulse to the CORDIC FSM.
ready_CORDIC  in  1  CORDIC result valid, held until acknowledged.
data_cordic  in  W  CORDIC result.
ACK_FSM_CORDIC  out  1  result-received acknowledge to the CORDIC FSM.
out_valid  out  1  result register occupied.
out_ready  in  1  consumer accepts the result.
out_data  out  W  result.
out_op  out  1  operation tag of the result.
count  out  AW+1  FIFO occupancy.
busy  out  1  (state != IDLE) or (count != 0) or out_valid.

Behaviour:
- Reset (reset = 0, asynchronous): FIFO emptied (count = 0, pointers = 0), state = IDLE. Outputs: beg_FSM_CORDIC = 0, ACK_FSM_CORDIC = 0, angle_cordic = 0, operation = 0, out_valid = 0, out_data = 0, out_op = 0, busy = 0, in_ready = 1. A job in flight is discarded and no ACK is sent.
- Push: in_valid & in_ready at an edge writes {in_op, in_angle} at the write pointer.
  - in_ready depends only on count; there is no pass-through when full, even if a pop occurs in the same cycle.
- Pop: only in IDLE with count != 0. The head entry is loaded into angle_cordic/operation at that edge.
  - A simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, START, WAIT, ACK.
  - IDLE: if count != 0, pop and go to START; otherwise stay.
  - START: beg_FSM_CORDIC = 1 for exactly this cycle; go to WAIT.
  - WAIT: when ready_CORDIC = 1 and the output register is free (out_valid = 0, or out_valid & out_ready this cycle):
    - capture data_cordic into out_data and operation into out_op;
    - set out_valid;
    - go to ACK.
    If ready_CORDIC = 1 but the output register is blocked, stay in WAIT with no ACK (backpressure onto the CORDIC).
  - ACK: ACK_FSM_CORDIC = 1 held while in ACK. Exit to IDLE on the first edge where ready_CORDIC = 0.
- angle_cordic/operation hold their value from pop until the next pop.
- Latency: a request accepted at edge k into an empty FIFO in IDLE is popped at edge k+1. beg_FSM_CORDIC is high during cycle k+1..k+2.
  - Result: ready_CORDIC sampled high at edge m with the output register free gives out_valid = 1 after edge m and ACK_FSM_CORDIC = 1 during cycle m..m+1.
- Output register:
  - out_valid clears on out_valid & out_ready unless a new capture happens at the same edge, in which case it stays 1 with the new data.
  - out_data is stable while out_valid & !out_ready.
- Issue is overlapped: the next job may start while out_valid is still pending.
- Jobs complete strictly in FIFO order; one job is in flight at a time.

Test Plan:
1. Reset (low) for 2 cycles, release; push angle 0x3F800000 with op = 1; CORDIC model raises ready_CORDIC 20 cycles after beg with data 0x3F576AA4 -> beg high exactly 1 cycle, 1 cycle after accept. Then out_valid = 1, out_data = 0x3F576AA4, out_op = 1; ACK high until ready_CORDIC falls; busy = 0 after consumption.
2. Push 5 requests back-to-back while the CORDIC is stalled -> in_ready = 0 once count = 4. The fifth request is held until a pop frees a slot, and results emerge in push order.
3. Hold out_ready = 0 with one result pending while the next job completes -> FSM stays in WAIT with ACK = 0. Raising out_ready releases it: the new result is captured on the same edge the old one drains, and out_valid stays 1.
4. Simultaneous push and pop at count = 1 -> count stays 1; the pointers wrap correctly after 9 total pushes.
5. Assert reset during WAIT with 2 entries queued -> count = 0, out_valid = 0, beg = ACK = 0 immediately (before the next edge). No stale job is issued after release.
